stage_f: RTL and testbench

Instruction fetch stage of the Polaris pipeline, directly upstream of the decode stage.
- Maintains the program counter and fetches 32-bit instructions over a Wishbone B4 classic master port, one transaction outstanding at a time.
- Presents each fetched word to decode with a one-cycle valid strobe.
- Accepts PC redirects from execute.
- When no instruction is available, presents the NOP encoding so decode latches a bubble.

---
 rtl/stage_f_pkg.sv | 15 +
 rtl/stage_f.sv | 110 +++++++++++
 tb/tb_stage_f.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_f_pkg.sv
// Shared Polaris front-end definitions: fetch FSM state encoding, the NOP
// bubble word (decode uses the same constant) and the default reset vector.
package stage_f_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] POLARIS_NOP          = 32'h0000_0013;
    localparam logic [63:0] POLARIS_RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;

endpackage

// File: rtl/stage_f.sv
// Polaris instruction fetch stage: PC register plus a Wishbone B4 classic
// master with one transaction in flight, feeding decode one word per strobe.
//
// state | meaning
// IDLE  | first cycle after reset, bus quiet
// FETCH | cycle/strobe asserted, ack delivers a word to decode
// FLUSH | redirected while a cycle was in flight; its ack/err is dropped
// HALT  | bus error seen, bus quiet until a redirect arrives
module stage_f
    import stage_f_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR = POLARIS_RESET_VECTOR,
    parameter logic [31:0] NOP_INSN     = POLARIS_NOP
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [63:0] i_adr_o,
    output logic        i_cyc_o,
    output logic        i_stb_o,
    input  logic        i_ack_i,
    input  logic        i_err_i,
    input  logic [31:0] i_dat_i,
    output logic        f_ack_o,
    output logic [31:0] f_dat_o,
    output logic [63:0] f_pc_o,
    output logic        f_err_o,
    input  logic        x_jump_i,
    input  logic [63:0] x_pc_i
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         f_ack_q, f_ack_d;
    logic [31:0]  f_dat_q, f_dat_d;
    logic [63:0]  f_pc_q, f_pc_d;
    logic         f_err_q, f_err_d;

    logic [63:0]  jump_pc;
    logic         bus_active;
    logic         bus_done;

    assign jump_pc    = x_pc_i & ~64'd3;
    assign bus_active = (state_q == ST_FETCH) || (state_q == ST_FLUSH);
    assign bus_done   = i_ack_i || i_err_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        f_ack_d = 1'b0;
        f_dat_d = NOP_INSN;
        f_pc_d  = f_pc_q;
        f_err_d = 1'b0;

        if (x_jump_i) begin
            pc_d = jump_pc;
            case (state_q)
                // an unfinished cycle keeps running; its response must be dropped
                ST_FETCH: state_d = bus_done ? ST_FETCH : ST_FLUSH;
                ST_FLUSH: state_d = ST_FLUSH;
                default:  state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (i_err_i) begin
                        f_err_d = 1'b1;
                        state_d = ST_HALT;
                    end else if (i_ack_i) begin
                        f_ack_d = 1'b1;
                        f_dat_d = i_dat_i;
                        f_pc_d  = pc_q;
                        pc_d    = pc_q + 64'd4;
                    end
                end
                ST_FLUSH: begin
                    if (bus_done) state_d = ST_FETCH;
                end
                default: state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            f_ack_q <= 1'b0;
            f_dat_q <= NOP_INSN;
            f_pc_q  <= 64'd0;
            f_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            f_ack_q <= f_ack_d;
            f_dat_q <= f_dat_d;
            f_pc_q  <= f_pc_d;
            f_err_q <= f_err_d;
        end
    end

    assign i_adr_o = pc_q;
    assign i_cyc_o = bus_active;
    assign i_stb_o = bus_active;
    assign f_ack_o = f_ack_q;
    assign f_dat_o = f_dat_q;
    assign f_pc_o  = f_pc_q;
    assign f_err_o = f_err_q;

endmodule

// File: tb/tb_stage_f.sv
// Bench for stage_f: directed scenarios plus random slave/redirect traffic,
// with expected deliveries queued by a reference model and checked by a monitor.
module tb_stage_f;

    localparam logic [63:0] RV  = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int M_IDLE = 0, M_FETCH = 1, M_FLUSH = 2, M_HALT = 3;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [63:0] i_adr_o;
    logic        i_cyc_o, i_stb_o;
    logic        i_ack_i = 1'b0, i_err_i = 1'b0;
    logic [31:0] i_dat_i = 32'd0;
    logic        f_ack_o;
    logic [31:0] f_dat_o;
    logic [63:0] f_pc_o;
    logic        f_err_o;
    logic        x_jump_i = 1'b0;
    logic [63:0] x_pc_i = 64'd0;

    stage_f dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .i_adr_o(i_adr_o), .i_cyc_o(i_cyc_o), .i_stb_o(i_stb_o),
        .i_ack_i(i_ack_i), .i_err_i(i_err_i), .i_dat_i(i_dat_i),
        .f_ack_o(f_ack_o), .f_dat_o(f_dat_o), .f_pc_o(f_pc_o), .f_err_o(f_err_o),
        .x_jump_i(x_jump_i), .x_pc_i(x_pc_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic [63:0] pc;
        logic [31:0] dat;
    } deliv_t;

    deliv_t      exp_q[$];
    int          err_q[$];
    int          checks = 0;
    int          failures = 0;
    int          pcount = 0;
    bit          run = 1'b0;
    int          m_st;
    logic [63:0] m_pc;

    always @(posedge clk_i) pcount++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle's decode-side outputs against queued expectations.
    always @(negedge clk_i) begin
        if (run) begin
            if (f_ack_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_f_ack", 64'd1, 64'd0);
                end else begin
                    deliv_t e;
                    e = exp_q.pop_front();
                    chk("f_pc", f_pc_o, e.pc);
                    chk("f_dat", {32'd0, f_dat_o}, {32'd0, e.dat});
                    chk("f_ack_timing", pcount, e.due);
                end
            end else begin
                chk("bubble_nop", {32'd0, f_dat_o}, {32'd0, NOP});
                if (exp_q.size() != 0 && exp_q[0].due <= pcount) begin
                    chk("missing_f_ack", 64'd0, 64'd1);
                    void'(exp_q.pop_front());
                end
            end
            if (f_err_o) begin
                if (err_q.size() == 0) chk("spurious_f_err", 64'd1, 64'd0);
                else chk("f_err_timing", pcount, err_q.pop_front());
            end else if (err_q.size() != 0 && err_q[0] <= pcount) begin
                chk("missing_f_err", 64'd0, 64'd1);
                void'(err_q.pop_front());
            end
        end
    end

    // One bus cycle: check the bus side against the model, drive inputs, advance the model.
    task automatic step(input bit ack, input bit err, input bit jmp,
                        input logic [63:0] jpc, input logic [31:0] dat);
        logic exp_bus;
        deliv_t e;
        exp_bus = (m_st == M_FETCH) || (m_st == M_FLUSH);
        chk("i_stb", {63'd0, i_stb_o}, {63'd0, exp_bus});
        chk("i_cyc", {63'd0, i_cyc_o}, {63'd0, exp_bus});
        chk("i_adr", i_adr_o, m_pc);
        i_ack_i = ack; i_err_i = err; x_jump_i = jmp; x_pc_i = jpc; i_dat_i = dat;
        if (jmp) begin
            if (m_st == M_FETCH) m_st = (ack || err) ? M_FETCH : M_FLUSH;
            else if (m_st != M_FLUSH) m_st = M_FETCH;
            m_pc = {jpc[63:2], 2'b00};
        end else if (m_st == M_IDLE) begin
            m_st = M_FETCH;
        end else if (m_st == M_FETCH) begin
            if (err) begin
                err_q.push_back(pcount + 1);
                m_st = M_HALT;
            end else if (ack) begin
                e.due = pcount + 1; e.pc = m_pc; e.dat = dat;
                exp_q.push_back(e);
                m_pc = m_pc + 64'd4;
            end
        end else if (m_st == M_FLUSH) begin
            if (ack || err) m_st = M_FETCH;
        end
        @(negedge clk_i);
    endtask

    task automatic idle_in();
        i_ack_i = 1'b0; i_err_i = 1'b0; x_jump_i = 1'b0; x_pc_i = 64'd0;
    endtask

    task automatic do_reset();
        run = 1'b0;
        reset_i = 1'b0;
        idle_in();
        exp_q.delete();
        err_q.delete();
        m_st = M_IDLE;
        m_pc = RV;
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_f_ack", {63'd0, f_ack_o}, 64'd0);
            chk("rst_f_dat", {32'd0, f_dat_o}, {32'd0, NOP});
            chk("rst_i_cyc", {63'd0, i_cyc_o}, 64'd0);
        end
        chk("rst_f_pc", f_pc_o, 64'd0);
        chk("rst_f_err", {63'd0, f_err_o}, 64'd0);
        reset_i = 1'b1;
        run = 1'b1;
    endtask

    initial begin
        logic [63:0] tgt;
        bit a, er, j;
        do_reset();

        // reset release, first strobe at the reset vector
        step(0, 0, 0, 64'd0, 32'd0);
        chk("first_stb", {63'd0, i_stb_o}, 64'd1);
        chk("first_adr", i_adr_o, RV);

        // zero-wait slave
        step(1, 0, 0, 64'd0, 32'h0010_0093);
        step(1, 0, 0, 64'd0, 32'h0020_0113);
        chk("adr_ff08", i_adr_o, 64'hFFFF_FFFF_FFFF_FF08);

        // two wait states then one ack
        step(0, 0, 0, 64'd0, 32'h1111_1111);
        step(0, 0, 0, 64'd0, 32'h2222_2222);
        step(1, 0, 0, 64'd0, 32'h3333_3333);

        // redirect while pending: late ack is dropped
        step(0, 0, 1, 64'h1003, 32'd0);
        chk("flush_adr", i_adr_o, 64'h1000);
        step(1, 0, 0, 64'd0, 32'hDEAD_BEEF);
        step(1, 0, 0, 64'd0, 32'h0030_0193);

        // redirect coincident with ack
        step(1, 0, 1, 64'h5000, 32'hBAD0_BAD0);
        chk("jump_ack_adr", i_adr_o, 64'h5000);
        step(1, 0, 0, 64'd0, 32'h0040_0213);

        // wrap-around from the top of the address space
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'd0);
        step(1, 0, 0, 64'd0, 32'h0BAD_0BAD);
        step(1, 0, 0, 64'd0, 32'h0050_0293);
        chk("wrap_adr", i_adr_o, 64'd0);

        // bus error halts fetching until a redirect
        step(1, 0, 1, 64'h2000, 32'h0);
        step(0, 1, 0, 64'd0, 32'h0);
        repeat (5) step(0, 0, 0, 64'd0, 32'h0);
        chk("halt_cyc", {63'd0, i_cyc_o}, 64'd0);
        step(0, 0, 1, 64'h3000, 32'd0);
        chk("restart_adr", i_adr_o, 64'h3000);
        step(1, 0, 0, 64'd0, 32'h0060_0313);

        // asynchronous reset in the middle of a cycle
        step(1, 0, 0, 64'd0, 32'h0070_0393);
        #2;
        chk("pre_rst_f_ack", {63'd0, f_ack_o}, 64'd1);
        run = 1'b0;
        reset_i = 1'b0;
        #1;
        chk("async_f_ack", {63'd0, f_ack_o}, 64'd0);
        chk("async_f_dat", {32'd0, f_dat_o}, {32'd0, NOP});
        chk("async_cyc", {63'd0, i_cyc_o}, 64'd0);
        chk("async_adr", i_adr_o, RV);
        @(negedge clk_i);
        do_reset();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            a  = ($urandom_range(99) < 55);
            er = ($urandom_range(99) < 4);
            j  = ($urandom_range(99) < 8);
            tgt = {$urandom, $urandom};
            if ($urandom_range(3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFE0 | {59'd0, tgt[4:0]};
            step(a, er, j, tgt, $urandom);
        end
        idle_in();
        repeat (3) @(negedge clk_i);
        chk("exp_q_drained", exp_q.size(), 64'd0);
        chk("err_q_drained", err_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
